// File: rtl/univ_reg_pkg.sv
// Shared definitions for the universal register: mode encoding and widths.
package univ_reg_pkg;

  localparam int unsigned MODE_W = 3;

  typedef enum logic [MODE_W-1:0] {
    HOLD = 3'b000,
    LOAD = 3'b001,
    SHR  = 3'b010,
    SHL  = 3'b011,
    ROR  = 3'b100,
    ROL  = 3'b101,
    UP   = 3'b110,
    DOWN = 3'b111
  } mode_e;

endpackage

// File: rtl/univ_reg.sv
// Universal register: WIDTH-bit clocked register with enable, asynchronous
// active-high reset, and hold/load/shift/rotate/count modes. Provides true and
// complement data, serial-out taps and a terminal-count flag.
module univ_reg
  import univ_reg_pkg::*;
#(
  parameter int unsigned       WIDTH     = 8,
  parameter logic [WIDTH-1:0]  RESET_VAL = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [MODE_W-1:0] mode,
  input  logic [WIDTH-1:0]  d,
  input  logic              sin_r,
  input  logic              sin_l,
  output logic [WIDTH-1:0]  Q,
  output logic [WIDTH-1:0]  Qn,
  output logic              sout_r,
  output logic              sout_l,
  output logic              tc
);

  mode_e            mode_sel;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] q_next;

  assign mode_sel = mode_e'(mode);

  // Next-state selection for the current mode.
  always_comb begin
    q_next = q;
    case (mode_sel)
      HOLD:    q_next = q;
      LOAD:    q_next = d;
      SHR:     q_next = {sin_r, q[WIDTH-1:1]};
      SHL:     q_next = {q[WIDTH-2:0], sin_l};
      ROR:     q_next = {q[0], q[WIDTH-1:1]};
      ROL:     q_next = {q[WIDTH-2:0], q[WIDTH-1]};
      UP:      q_next = q + 1'b1;
      DOWN:    q_next = q - 1'b1;
      default: q_next = q;
    endcase
  end

  // State register: reset dominates, enable gates every update.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      q <= RESET_VAL;
    else if (en)
      q <= q_next;
  end

  // Combinational outputs derived from the held value, mode and enable.
  always_comb begin
    Q      = q;
    Qn     = ~q;
    sout_r = q[0];
    sout_l = q[WIDTH-1];
    tc     = en & (((mode_sel == UP)   && (q == '1)) ||
                   ((mode_sel == DOWN) && (q == '0)));
  end

endmodule

// File: tb/tb_univ_reg.sv
// Directed bench for univ_reg (WIDTH=8, RESET_VAL=8'hA5): a vector table for
// single-edge operations plus hand sequences for reset behaviour.
module tb_univ_reg;
  import univ_reg_pkg::*;

  localparam int unsigned W = 8;
  localparam logic [W-1:0] RV = 8'hA5;

  logic         clk = 1'b0;
  logic         rst;
  logic         en;
  logic [2:0]   mode;
  logic [W-1:0] d;
  logic         sin_r;
  logic         sin_l;
  logic [W-1:0] Q;
  logic [W-1:0] Qn;
  logic         sout_r;
  logic         sout_l;
  logic         tc;

  int tests_run = 0;
  int tests_failed = 0;

  univ_reg #(.WIDTH(W), .RESET_VAL(RV)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .d(d),
    .sin_r(sin_r), .sin_l(sin_l), .Q(Q), .Qn(Qn),
    .sout_r(sout_r), .sout_l(sout_l), .tc(tc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         en;
    mode_e        mode;
    logic [W-1:0] d;
    logic         sin_r;
    logic         sin_l;
    logic [W-1:0] pre_q;   // Q expected before the edge
    logic         pre_tc;  // tc expected before the edge
    logic [W-1:0] exp_q;   // Q expected after the edge
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic e, input mode_e m, input logic [W-1:0] dd,
                     input logic sr, input logic sl, input logic [W-1:0] pq,
                     input logic ptc, input logic [W-1:0] eq);
    vec_t v;
    v.en = e; v.mode = m; v.d = dd; v.sin_r = sr; v.sin_l = sl;
    v.pre_q = pq; v.pre_tc = ptc; v.exp_q = eq;
    tbl.push_back(v);
  endtask

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_q(input string name, input logic [W-1:0] exp);
    check({name, ".Q"}, Q, exp);
    check({name, ".Qn"}, Qn, ~exp);
  endtask

  task automatic drive(input logic e, input mode_e m, input logic [W-1:0] dd,
                       input logic sr, input logic sl);
    en = e; mode = m; d = dd; sin_r = sr; sin_l = sl;
  endtask

  initial begin
    // Vectors run back-to-back starting from Q = RESET_VAL.
    //   en  mode  d      sr  sl  pre_q  tc  exp_q
    add(1, LOAD, 8'h3C, 0, 0, 8'hA5, 0, 8'h3C);
    add(0, LOAD, 8'h00, 0, 0, 8'h3C, 0, 8'h3C);
    add(0, LOAD, 8'h00, 0, 0, 8'h3C, 0, 8'h3C);
    add(0, LOAD, 8'h00, 0, 0, 8'h3C, 0, 8'h3C);
    add(1, HOLD, 8'hFF, 1, 1, 8'h3C, 0, 8'h3C);
    add(1, LOAD, 8'h81, 0, 0, 8'h3C, 0, 8'h81);
    add(1, SHR,  8'h00, 0, 1, 8'h81, 0, 8'h40);
    add(1, LOAD, 8'h81, 0, 0, 8'h40, 0, 8'h81);
    add(1, SHL,  8'h00, 0, 1, 8'h81, 0, 8'h03);
    add(1, LOAD, 8'h81, 0, 0, 8'h03, 0, 8'h81);
    add(1, ROR,  8'h00, 0, 0, 8'h81, 0, 8'hC0);
    add(1, LOAD, 8'h81, 0, 0, 8'hC0, 0, 8'h81);
    add(1, ROL,  8'h00, 0, 0, 8'h81, 0, 8'h03);
    add(1, LOAD, 8'h81, 0, 0, 8'h03, 0, 8'h81);
    add(1, ROR,  8'h00, 1, 1, 8'h81, 0, 8'hC0);
    add(1, ROR,  8'h00, 1, 1, 8'hC0, 0, 8'h60);
    add(1, ROR,  8'h00, 1, 1, 8'h60, 0, 8'h30);
    add(1, ROR,  8'h00, 1, 1, 8'h30, 0, 8'h18);
    add(1, ROR,  8'h00, 1, 1, 8'h18, 0, 8'h0C);
    add(1, ROR,  8'h00, 1, 1, 8'h0C, 0, 8'h06);
    add(1, ROR,  8'h00, 1, 1, 8'h06, 0, 8'h03);
    add(1, ROR,  8'h00, 1, 1, 8'h03, 0, 8'h81);
    add(1, LOAD, 8'hFE, 0, 0, 8'h81, 0, 8'hFE);
    add(1, UP,   8'h00, 0, 0, 8'hFE, 0, 8'hFF);
    add(1, UP,   8'h00, 0, 0, 8'hFF, 1, 8'h00);
    add(1, DOWN, 8'h00, 0, 0, 8'h00, 1, 8'hFF);
    add(0, UP,   8'h00, 0, 0, 8'hFF, 0, 8'hFF);
    add(0, UP,   8'h00, 0, 0, 8'hFF, 0, 8'hFF);
    add(1, UP,   8'h00, 0, 0, 8'hFF, 1, 8'h00);
    add(1, SHR,  8'h00, 1, 0, 8'h00, 0, 8'h80);
    add(1, SHL,  8'h00, 0, 0, 8'h80, 0, 8'h00);
    add(0, DOWN, 8'h00, 0, 0, 8'h00, 0, 8'h00);
    add(1, DOWN, 8'h00, 0, 0, 8'h00, 1, 8'hFF);

    // Reset from time zero, with LOAD of all-ones requested: Q must stay RV.
    rst = 1'b1;
    drive(1, LOAD, 8'hFF, 0, 0);
    #2;
    check_q("rst_async_start", RV);
    repeat (2) @(posedge clk);
    #1;
    check_q("rst_over_load", RV);
    check("rst_tc", {7'b0, tc}, 8'h00);
    check("rst_sout_r", {7'b0, sout_r}, {7'b0, RV[0]});
    check("rst_sout_l", {7'b0, sout_l}, {7'b0, RV[W-1]});
    rst = 1'b0;

    // Table-driven single-edge operations.
    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].en, tbl[i].mode, tbl[i].d, tbl[i].sin_r, tbl[i].sin_l);
      #1;
      check($sformatf("v%0d.pre_q", i), Q, tbl[i].pre_q);
      check($sformatf("v%0d.sout_r", i), {7'b0, sout_r}, {7'b0, tbl[i].pre_q[0]});
      check($sformatf("v%0d.sout_l", i), {7'b0, sout_l}, {7'b0, tbl[i].pre_q[W-1]});
      check($sformatf("v%0d.tc", i), {7'b0, tc}, {7'b0, tbl[i].pre_tc});
      @(posedge clk);
      #1;
      check_q($sformatf("v%0d.post", i), tbl[i].exp_q);
    end

    // Asynchronous reset asserted between edges takes effect immediately.
    drive(1, LOAD, 8'h3C, 0, 0);
    @(posedge clk);
    #1;
    check_q("pre_mid_rst", 8'h3C);
    #2;
    rst = 1'b1;
    drive(1, LOAD, 8'hFF, 0, 0);
    #1;
    check_q("mid_rst_immediate", RV);
    @(posedge clk);
    #1;
    check_q("mid_rst_hold_edge", RV);
    rst = 1'b0;

    // Reset mid-count, then counting resumes from RV on the first free edge.
    drive(1, LOAD, 8'h10, 0, 0);
    @(posedge clk);
    #1;
    drive(1, UP, 8'h00, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    check_q("count_3_edges", 8'h13);
    #1;
    rst = 1'b1;
    #1;
    check_q("count_rst_immediate", RV);
    @(posedge clk);
    #1;
    check_q("count_rst_edge", RV);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check_q("count_resume_1", RV + 8'd1);
    @(posedge clk);
    #1;
    check_q("count_resume_2", RV + 8'd2);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/univ_reg.md
# univ_reg

Parametrised universal register: a WIDTH-bit clocked register with enable, asynchronous reset and eight operating modes (hold, parallel load, shift, rotate, up/down count). Outputs are true and complement data plus serial-out and terminal-count flags. It is the clocked, multi-bit successor to the single-bit level-sensitive D latch in the Sequential library. Intended uses are datapath staging, serial/parallel conversion and loadable counters.

## Interface
- WIDTH, 8: register width in bits, ≥ 2.
- RESET_VAL, '0: value loaded into Q on reset, WIDTH bits.
- clk  input  1  clock; all state changes occur on the rising edge.
- rst  input  1  reset, asynchronous, active-high; forces Q = RESET_VAL while high.
- en  input  1  clock enable; when 0 the register holds regardless of mode.
- mode  input  3  operation select (see Operation).
- d  input  WIDTH  parallel load data.
- sin_r  input  1  serial input for shift-right; enters the MSB.
- sin_l  input  1  serial input for shift-left; enters the LSB.
- Q  output  WIDTH  register contents.
- Qn  output  WIDTH  bitwise complement of Q, always ~Q.
- sout_r  output  1  Q[0], the bit shifted out by shift-right.
- sout_l  output  1  Q[WIDTH-1], the bit shifted out by shift-left.
- tc  output  1  terminal count flag (combinational).

## Operation
Next state applies on a rising clk edge with en=1 and rst=0:
- 000 HOLD: Q unchanged.
- 001 LOAD: Q ← d.
- 010 SHR: Q ← {sin_r, Q[WIDTH-1:1]}.
- 011 SHL: Q ← {Q[WIDTH-2:0], sin_l}.
- 100 ROR: Q ← {Q[0], Q[WIDTH-1:1]}.
- 101 ROL: Q ← {Q[WIDTH-2:0], Q[WIDTH-1]}.
- 110 UP: Q ← Q + 1, modulo 2^WIDTH. All-ones wraps to zero.
- 111 DOWN: Q ← Q − 1, modulo 2^WIDTH. Zero wraps to all-ones.

Flags and complements:
- tc = en & ((mode==UP & Q=={WIDTH{1}}) | (mode==DOWN & Q==0)). It is 0 in every other mode.
- Qn, sout_r, sout_l and tc are combinational from Q, mode and en. No extra registers.

## Timing
- Reset: rst asserted at any time drives Q = RESET_VAL and Qn = ~RESET_VAL immediately, with no clock edge needed.
  - With the default RESET_VAL, the reset values are: sout_r = 0, sout_l = 0, tc = 0 unless mode/en select a terminal condition (e.g. DOWN with en=1 gives tc = 1).
- Reset has priority over en and mode.
- Reset deasserting mid-operation: the first rising edge with rst=0 applies the current mode to RESET_VAL.
- Latency: one cycle. Q reflects the operation selected at edge n immediately after edge n.
- mode, d, sin_r, sin_l and en are sampled only at the rising edge. Changes between edges have no effect on Q.
- tc is valid in the same cycle as the Q value it describes, so the wrap occurs on the edge where tc=1.
- en=0 at an edge: Q holds, including in UP/DOWN. tc is forced to 0.

## Structure
- Shared package univ_reg_pkg holds:
  - mode_e, a 3-bit enum: HOLD, LOAD, SHR, SHL, ROR, ROL, UP, DOWN.
  - Constant MODE_W = 3.
- Single module, with no sub-module. The next-state mux is one combinational case over mode_e, feeding one always_ff with async reset.

## Test plan
- Async reset: WIDTH=8, RESET_VAL=8'hA5. Assert rst between clock edges → Q=8'hA5 and Qn=8'h5A before the next edge. Drive mode=LOAD with d=8'hFF during reset → Q stays 8'hA5.
- Load/hold/enable: load 8'h3C → Q=8'h3C next cycle. Then mode=LOAD, d=8'h00, en=0 for 3 cycles → Q stays 8'h3C. HOLD with en=1 → Q stays 8'h3C.
- Shifts: Q=8'h81.
  - SHR with sin_r=0 → Q=8'h40, sout_r=0.
  - From 8'h81, SHL with sin_l=1 → Q=8'h03, and sout_l=1 before the edge.
- Rotates: Q=8'h81, ROR → 8'hC0. From 8'h81, ROL → 8'h03. Eight consecutive ROR → 8'h81.
- Count wrap: load 8'hFE, UP.
  - Q: 8'hFF (tc=1), then 8'h00 (tc=0).
  - Then DOWN → tc=1 at 8'h00, next Q=8'hFF.
  - Deassert en while in UP at 8'hFF → tc=0 and Q holds.
- Reset mid-count: UP from 8'h10. Assert rst after 3 edges (Q=8'h13) → Q=RESET_VAL immediately. Release → counting resumes from RESET_VAL+1 on the first edge.
